// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, state type and digit helpers for the BCD serial adder
package bcd_pkg;

    localparam int         DIGIT_W   = 4;
    localparam logic [3:0] MAX_DIGIT = 4'd9;
    localparam logic [3:0] CORR      = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wraps modulo 16, so an invalid digit (10..15) maps to another invalid digit.
    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return MAX_DIGIT - d;
    endfunction

endpackage

// File: rtl/bcd_digit_stage.sv
// rtl/bcd_digit_stage.sv - combinational single-digit BCD adder with decimal correction
module bcd_digit_stage
    import bcd_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       bad
);

    logic [4:0] w_raw;

    assign w_raw = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, ci};
    assign co    = (w_raw > {1'b0, MAX_DIGIT});
    assign s     = co ? (w_raw[3:0] + CORR) : w_raw[3:0];
    assign bad   = (a_d > MAX_DIGIT) | (b_d > MAX_DIGIT);

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial multi-digit BCD add controller (BCD_SUB_EN adds nines'-complement subtract)
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   a,
    input  logic [4*NDIGITS-1:0]   b,
    input  logic                   cin,
`ifdef BCD_SUB_EN
    input  logic                   sub,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   sum,
    output logic                   cout,
    output logic                   error
);

    localparam int                 W        = DIGIT_W * NDIGITS;
    localparam int                 IDX_W    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NDIGITS - 1);

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_error;
    logic               w_busy;
    logic               w_done;
    logic [3:0]         w_a_d;
    logic [3:0]         w_b_raw;
    logic [3:0]         w_b_d;
    logic [3:0]         w_s;
    logic               w_co;
    logic               w_bad;
    logic               w_init_carry;

    assign w_a_d   = r_a[r_idx*DIGIT_W +: DIGIT_W];
    assign w_b_raw = r_b[r_idx*DIGIT_W +: DIGIT_W];

`ifdef BCD_SUB_EN
    logic r_sub;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sub <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_sub <= sub;
        end
    end

    assign w_b_d        = r_sub ? nines_comp(w_b_raw) : w_b_raw;
    assign w_init_carry = sub | cin;
`else
    assign w_b_d        = w_b_raw;
    assign w_init_carry = cin;
`endif

    // Nines' complement keeps digits >9 out of range, so the stage's check on w_b_d matches the raw b digit.
    bcd_digit_stage u_stage (
        .a_d (w_a_d),
        .b_d (w_b_d),
        .ci  (r_carry),
        .s   (w_s),
        .co  (w_co),
        .bad (w_bad)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: if (start) w_next = ADD;
            ADD: begin
                w_busy = 1'b1;
                if (r_idx == LAST_IDX) w_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_idx   <= '0;
                        r_carry <= w_init_carry;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_error <= 1'b0;
                    end
                end
                ADD: begin
                    r_sum[r_idx*DIGIT_W +: DIGIT_W] <= w_s;
                    r_carry <= w_co;
                    r_error <= r_error | w_bad;
                    if (r_idx == LAST_IDX) begin
                        r_cout <= w_co;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = w_busy;
    assign done  = w_done;
    assign sum   = r_sum;
    assign cout  = r_cout;
    assign error = r_error;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - self-checking bench for bcd_serial_add_ctrl against a decimal reference model
module tb_bcd_serial_add_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         error;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bcd_serial_add_ctrl #(.NDIGITS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef BCD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .error (error)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Valid operands use whole-number decimal arithmetic; invalid digits fall back to the per-digit rule.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mcin, input logic msub,
                                  output logic [W-1:0] ms, output logic mco, output logic merr);
        bit     valid = 1'b1;
        longint av = 0, bv = 0, p = 1, tot;
        int     c, ad, bd, r;
        merr = 1'b0;
        ms   = '0;
        for (int i = 0; i < N; i++) begin
            ad = int'(ma[4*i +: 4]);
            bd = int'(mb[4*i +: 4]);
            if (ad > 9 || bd > 9) begin
                valid = 1'b0;
                merr  = 1'b1;
            end
        end
        if (valid) begin
            for (int i = 0; i < N; i++) begin
                av += longint'(ma[4*i +: 4]) * p;
                bv += longint'(mb[4*i +: 4]) * p;
                p  *= 10;
            end
            tot = msub ? (av + (p - 1 - bv) + 1) : (av + bv + longint'(mcin));
            mco = (tot >= p);
            tot = tot % p;
            for (int i = 0; i < N; i++) begin
                ms[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            c = msub ? 1 : int'(mcin);
            for (int i = 0; i < N; i++) begin
                ad = int'(ma[4*i +: 4]);
                bd = int'(mb[4*i +: 4]);
                if (msub) bd = (9 - bd) & 15;
                r = ad + bd + c;
                if (r > 9) begin
                    ms[4*i +: 4] = 4'((r + 6) & 15);
                    c = 1;
                end else begin
                    ms[4*i +: 4] = 4'(r);
                    c = 0;
                end
            end
            mco = c[0];
        end
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tcin, input logic tsub, input string tag);
        logic [W-1:0] es;
        logic         ec, ee;
        model(ta, tb_v, tcin, tsub, es, ec, ee);
        a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        for (int k = 0; k <= N + 1; k++) begin
            chk($sformatf("%s_busy_k%0d", tag, k), W'(busy), W'(k < N));
            chk($sformatf("%s_done_k%0d", tag, k), W'(done), W'(k == N));
            if (k < N + 1) begin
                @(posedge clk); #1;
            end
        end
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, W'(cout), W'(ec));
        chk({tag, "_error"}, W'(error), W'(ee));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;

        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_sum", sum, '0);
        chk("rst_cout", W'(cout), '0);
        chk("rst_error", W'(error), '0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h8766, 1'b0, 1'b0, "d_wrap");
        run_op(16'h0999, 16'h0001, 1'b1, 1'b0, "d_cin");
        run_op(16'h00A0, 16'h0000, 1'b0, 1'b0, "d_bad");
        run_op(16'h9999, 16'h9999, 1'b1, 1'b0, "d_max");

        // start held high: one result from the captured operands, then a re-trigger from IDLE
        a = 16'h1234; b = 16'h8766; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h1111;
        for (int k = 0; k <= 11; k++) begin
            chk($sformatf("hold_busy_k%0d", k), W'(busy), W'((k < 4) || (k >= 6 && k <= 9)));
            chk($sformatf("hold_done_k%0d", k), W'(done), W'(k == 4 || k == 10));
            if (k == 4) begin
                chk("hold_sum1", sum, 16'h0000);
                chk("hold_cout1", W'(cout), W'(1'b1));
            end
            if (k == 10) begin
                chk("hold_sum2", sum, 16'h2222);
                chk("hold_cout2", W'(cout), W'(1'b0));
            end
            if (k == 6) start = 1'b0;
            @(posedge clk); #1;
        end

        // reset during the second ADD cycle aborts with no done pulse
        a = 16'h000B; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("abort_err_set", W'(error), W'(1'b1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_sum", sum, '0);
        chk("abort_error", W'(error), '0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("abort_nodone_k%0d", k), W'(done), '0);
            @(posedge clk); #1;
        end
        run_op(16'h4321, 16'h1234, 1'b0, 1'b0, "after_abort");

`ifdef BCD_SUB_EN
        run_op(16'h0500, 16'h0123, 1'b0, 1'b1, "sub_pos");
        run_op(16'h0100, 16'h0200, 1'b1, 1'b1, "sub_neg");
`endif

        for (int n = 0; n < 24; n++) begin
            ra = '0;
            rb = '0;
            for (int i = 0; i < N; i++) begin
                ra[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                rb[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            rs = 1'b0;
`ifdef BCD_SUB_EN
            rs = 1'($urandom_range(0, 1));
`endif
            run_op(ra, rb, 1'($urandom_range(0, 1)), rs, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
- Digit-serial controller for multi-digit BCD addition using one shared 1-digit BCD adder stage.
- Captures two NDIGITS-digit BCD operands on a start pulse and walks digits LSD to MSD, one per clock, through the stage.
- Registers a carry between digits and accumulates sum digits; signals completion with a one-cycle done pulse.
- Sits between switch/key input capture and the HEX/LEDR display logic in the lab top levels.

Parameters:
NDIGITS, 4, number of BCD digits per operand (legal 1..8)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only in IDLE
a  input  4*NDIGITS  operand A, packed BCD, digit 0 in [3:0]
b  input  4*NDIGITS  operand B, packed BCD
cin  input  1  carry-in to digit 0
busy  output  1  high while a request is in progress
done  output  1  one-cycle pulse when the result is final
sum  output  4*NDIGITS  packed BCD result
cout  output  1  carry out of MSD
error  output  1  high if any captured input digit was >9

Behaviour:
- Reset (sync, active-high, highest priority):
  - state=IDLE, idx=0, carry=0.
  - busy=0, done=0, sum=0, cout=0, error=0.
  - Reset mid-operation aborts immediately; no done pulse is produced.
- States: IDLE, ADD, DONE.
- IDLE: start=1 on a clock edge captures a, b, cin into internal registers.
  - Clears sum, cout and error; sets idx=0 and carry=cin.
  - Goes to ADD with busy=1 on the next cycle.
- ADD: each cycle processes digit idx.
  - raw = a_d + b_d + carry (5-bit).
  - If raw>9: s=(raw+6)[3:0], c=1; otherwise s=raw[3:0], c=0.
  - sum[idx] <= s; carry <= c; error <= error | (a_d>9) | (b_d>9).
  - If idx==NDIGITS-1: cout <= c and go to DONE; otherwise idx <= idx+1.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency: start sampled at edge t gives done high in cycle t+NDIGITS+1.
- start in ADD or DONE is ignored (not queued). start held high re-triggers only once back in IDLE.
- sum, cout and error hold their values from DONE until the next accepted start.
- Invalid digits (>9): the correction rule above still applies and a result is still produced; error is sticky for the request.
- Input ports a, b and cin are don't-care after capture.

Optional Feature:
- Macro: BCD_SUB_EN.
- Defined: adds input port sub (1 bit), captured with the operands at start.
  - When sub=1, every b digit is replaced by its nines' complement (9-b_d) and the initial carry is forced to 1 (cin ignored).
  - cout=1 means no borrow (a>=b); cout=0 means the result is the ten's complement.
  - The error check applies to the raw b digits before complementing.
- Undefined: port sub is absent and behaviour is add-only as above.

Decomposition:
- Package bcd_pkg:
  - DIGIT_W=4, MAX_DIGIT=4'd9, CORR=4'd6.
  - State enum typedef {IDLE, ADD, DONE}.
  - Function nines_comp.
- Sub-module bcd_digit_stage: combinational 1-digit adder (a_d, b_d, ci -> s, co, bad).
  - The controller instantiates exactly one and muxes digit idx into it.

Test Plan:
- NDIGITS=4, a=0x1234, b=0x8766, cin=0, start pulse -> done 5 cycles after start edge; sum=0x0000, cout=1, error=0.
- a=0x0999, b=0x0001, cin=1 -> sum=0x1001, cout=0, error=0; busy high for exactly 4 cycles.
- a=0x00A0, b=0x0000, cin=0 -> sum=0x0100, cout=0, error=1.
- start held high through the operation, with a/b changed to 0x1111/0x1111 after capture -> first result unaffected; exactly one done pulse; a second request begins only in the cycle after DONE returns to IDLE.
- reset asserted during the 2nd ADD cycle -> next cycle busy=0, sum=0, error=0, no done; a fresh start then completes normally.
- BCD_SUB_EN, sub=1: a=0x0500, b=0x0123 -> sum=0x0377, cout=1; a=0x0100, b=0x0200 -> sum=0x9900, cout=0.
